// File: rtl/ahb_apb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ahb_apb_pkg
// Brief    : Shared types and constants for the AHB-Lite to APB3 bridge.
// Revision : 1.0
// ============================================================================
package ahb_apb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WDAT   = 3'd1,
        ST_SETUP  = 3'd2,
        ST_ACCESS = 3'd3,
        ST_DONE   = 3'd4,
        ST_ERR1   = 3'd5,
        ST_ERR2   = 3'd6
    } state_t;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [7:0]  DEF_APB_BASE = 8'h40;
    localparam int unsigned DEF_SLOT_LSB = 20;
    localparam int unsigned TIMER_SLOT   = 1;

endpackage
`default_nettype wire

// File: rtl/apb_slot_decoder.sv
`default_nettype none
// ============================================================================
// Module   : apb_slot_decoder
// Brief    : Address to APB slot decode plus per-slot response muxing.
// Revision : 1.0
// ============================================================================
module apb_slot_decoder
    import ahb_apb_pkg::*;
#(
    parameter int unsigned NSLV     = 4,
    parameter logic [7:0]  APB_BASE = DEF_APB_BASE,
    parameter int unsigned SLOT_LSB = DEF_SLOT_LSB,
    localparam int unsigned IDXW    = $clog2(NSLV),
    localparam int unsigned HIW     = 32 - SLOT_LSB
) (
    input  logic [HIW-1:0]     i_addr_hi,
    output logic               o_hit,
    output logic [NSLV-1:0]    o_sel,
    output logic [IDXW-1:0]    o_idx,
    input  logic [IDXW-1:0]    i_mux_idx,
    input  logic [32*NSLV-1:0] i_prdata,
    input  logic [NSLV-1:0]    i_pready,
    input  logic [NSLV-1:0]    i_pslverr,
    output logic [31:0]        o_prdata,
    output logic               o_pready,
    output logic               o_pslverr
);

    // Full slot field spans up to bit 23 so out-of-range slots are caught.
    localparam int unsigned FW = 24 - SLOT_LSB;

    logic [FW-1:0] w_field;
    logic [31:0]   w_rdata [NSLV];

    assign w_field = i_addr_hi[FW-1:0];
    assign o_idx   = w_field[IDXW-1:0];
    assign o_hit   = (i_addr_hi[HIW-1 -: 8] == APB_BASE) && (32'(w_field) < NSLV);
    assign o_sel   = o_hit ? (NSLV'(1) << o_idx) : '0;

    for (genvar g = 0; g < NSLV; g++) begin : g_rdata
        assign w_rdata[g] = i_prdata[32*g +: 32];
    end

    assign o_prdata  = w_rdata[i_mux_idx];
    assign o_pready  = i_pready[i_mux_idx];
    assign o_pslverr = i_pslverr[i_mux_idx];

endmodule
`default_nettype wire

// File: rtl/ahb2apb_bridge.sv
`default_nettype none
// ============================================================================
// Module   : ahb2apb_bridge
// Brief    : AHB-Lite slave to APB3 master bridge, one transfer at a time.
// Revision : 1.0
// ============================================================================
module ahb2apb_bridge
    import ahb_apb_pkg::*;
#(
    parameter int unsigned NSLV     = 4,
    parameter logic [7:0]  APB_BASE = DEF_APB_BASE,
    parameter int unsigned SLOT_LSB = DEF_SLOT_LSB,
    parameter int unsigned TIMEOUT  = 255
) (
    input  logic               HCLK,
    input  logic               HRESET,
    input  logic               HSEL,
    input  logic [31:0]        HADDR,
    input  logic [1:0]         HTRANS,
    input  logic               HWRITE,
    input  logic [2:0]         HSIZE,
    input  logic               HREADY,
    input  logic [31:0]        HWDATA,
    output logic [31:0]        HRDATA,
    output logic               HREADYOUT,
    output logic               HRESP,
    output logic [31:0]        PADDR,
    output logic [NSLV-1:0]    PSEL,
    output logic               PENABLE,
    output logic               PWRITE,
    output logic [31:0]        PWDATA,
    input  logic [32*NSLV-1:0] PRDATA,
    input  logic [NSLV-1:0]    PREADY,
    input  logic [NSLV-1:0]    PSLVERR
);

    localparam int unsigned IDXW = $clog2(NSLV);
    localparam int unsigned CNTW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    state_t            r_state_q,     w_state_d;
    logic [IDXW-1:0]   r_slot_q,      w_slot_d;
    logic [NSLV-1:0]   r_sel_q,       w_sel_d;
    logic [CNTW-1:0]   r_cnt_q,       w_cnt_d;
    logic [31:0]       r_hrdata_q,    w_hrdata_d;
    logic              r_hreadyout_q, w_hreadyout_d;
    logic              r_hresp_q,     w_hresp_d;
    logic [NSLV-1:0]   r_psel_q,      w_psel_d;
    logic              r_penable_q,   w_penable_d;
    logic [31:0]       r_paddr_q,     w_paddr_d;
    logic              r_pwrite_q,    w_pwrite_d;
    logic [31:0]       r_pwdata_q,    w_pwdata_d;

    logic              w_accept;
    logic              w_hit;
    logic [NSLV-1:0]   w_dec_sel;
    logic [IDXW-1:0]   w_dec_idx;
    logic [31:0]       w_slv_rdata;
    logic              w_slv_ready;
    logic              w_slv_err;
    logic              w_unused;

    // Transfer size is irrelevant: every access is a word access.
    assign w_unused = ^{HSIZE, HADDR[1:0]};
    assign w_accept = HSEL && HREADY && ((HTRANS == HTRANS_NONSEQ) || (HTRANS == HTRANS_SEQ));

    apb_slot_decoder #(
        .NSLV     (NSLV),
        .APB_BASE (APB_BASE),
        .SLOT_LSB (SLOT_LSB)
    ) u_dec (
        .i_addr_hi (HADDR[31:SLOT_LSB]),
        .o_hit     (w_hit),
        .o_sel     (w_dec_sel),
        .o_idx     (w_dec_idx),
        .i_mux_idx (r_slot_q),
        .i_prdata  (PRDATA),
        .i_pready  (PREADY),
        .i_pslverr (PSLVERR),
        .o_prdata  (w_slv_rdata),
        .o_pready  (w_slv_ready),
        .o_pslverr (w_slv_err)
    );

    always_comb begin
        w_state_d  = r_state_q;
        w_slot_d   = r_slot_q;
        w_sel_d    = r_sel_q;
        w_cnt_d    = r_cnt_q;
        w_hrdata_d = r_hrdata_q;
        w_paddr_d  = r_paddr_q;
        w_pwrite_d = r_pwrite_q;
        w_pwdata_d = r_pwdata_q;

        case (r_state_q)
            ST_IDLE, ST_DONE, ST_ERR2: begin
                w_state_d = ST_IDLE;
                if (w_accept) begin
                    if (!w_hit) begin
                        w_state_d = ST_ERR1;
                    end else begin
                        w_state_d  = HWRITE ? ST_WDAT : ST_SETUP;
                        w_slot_d   = w_dec_idx;
                        w_sel_d    = w_dec_sel;
                        w_paddr_d  = {HADDR[31:2], 2'b00};
                        w_pwrite_d = HWRITE;
                    end
                end
            end
            ST_WDAT: begin
                w_pwdata_d = HWDATA;
                w_state_d  = ST_SETUP;
            end
            ST_SETUP: begin
                w_state_d = ST_ACCESS;
            end
            ST_ACCESS: begin
                w_cnt_d = r_cnt_q + CNTW'(1);
                if (w_slv_ready) begin
                    if (w_slv_err) begin
                        w_state_d = ST_ERR1;
                    end else begin
                        w_state_d = ST_DONE;
                        if (!r_pwrite_q) w_hrdata_d = w_slv_rdata;
                    end
                end else if ((TIMEOUT != 0) && (r_cnt_q == CNTW'(TIMEOUT))) begin
                    w_state_d = ST_ERR1;
                end
            end
            ST_ERR1: begin
                w_state_d = ST_ERR2;
            end
            default: begin
                w_state_d = ST_IDLE;
            end
        endcase

        if (w_state_d == ST_SETUP) w_cnt_d = '0;

        // Outputs are decoded from the next state so every port is a flop.
        w_hreadyout_d = (w_state_d inside {ST_IDLE, ST_DONE, ST_ERR2});
        w_hresp_d     = (w_state_d inside {ST_ERR1, ST_ERR2});
        w_psel_d      = (w_state_d inside {ST_SETUP, ST_ACCESS}) ? w_sel_d : '0;
        w_penable_d   = (w_state_d == ST_ACCESS);
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            r_state_q     <= ST_IDLE;
            r_slot_q      <= '0;
            r_sel_q       <= '0;
            r_cnt_q       <= '0;
            r_hrdata_q    <= '0;
            r_hreadyout_q <= 1'b1;
            r_hresp_q     <= 1'b0;
            r_psel_q      <= '0;
            r_penable_q   <= 1'b0;
            r_paddr_q     <= '0;
            r_pwrite_q    <= 1'b0;
            r_pwdata_q    <= '0;
        end else begin
            r_state_q     <= w_state_d;
            r_slot_q      <= w_slot_d;
            r_sel_q       <= w_sel_d;
            r_cnt_q       <= w_cnt_d;
            r_hrdata_q    <= w_hrdata_d;
            r_hreadyout_q <= w_hreadyout_d;
            r_hresp_q     <= w_hresp_d;
            r_psel_q      <= w_psel_d;
            r_penable_q   <= w_penable_d;
            r_paddr_q     <= w_paddr_d;
            r_pwrite_q    <= w_pwrite_d;
            r_pwdata_q    <= w_pwdata_d;
        end
    end

    assign HRDATA    = r_hrdata_q;
    assign HREADYOUT = r_hreadyout_q;
    assign HRESP     = r_hresp_q;
    assign PADDR     = r_paddr_q;
    assign PSEL      = r_psel_q;
    assign PENABLE   = r_penable_q;
    assign PWRITE    = r_pwrite_q;
    assign PWDATA    = r_pwdata_q;

endmodule
`default_nettype wire

// File: tb/tb_ahb2apb_bridge.sv
`default_nettype none
// ============================================================================
// Module   : tb_ahb2apb_bridge
// Brief    : Randomised self-checking bench with a transaction-level model.
// Revision : 1.0
// ============================================================================
module tb_ahb2apb_bridge;

    localparam int NSLV = 4;
    localparam int TMO  = 4;

    logic                HCLK = 1'b0;
    logic                HRESET, HSEL, HWRITE, HREADY;
    logic [31:0]         HADDR, HWDATA;
    logic [1:0]          HTRANS;
    logic [2:0]          HSIZE;
    logic [31:0]         HRDATA, PADDR, PWDATA;
    logic                HREADYOUT, HRESP, PENABLE, PWRITE;
    logic [NSLV-1:0]     PSEL, PREADY, PSLVERR;
    logic [32*NSLV-1:0]  PRDATA;

    always #5 HCLK = ~HCLK;

    ahb2apb_bridge #(.NSLV(NSLV), .APB_BASE(8'h40), .SLOT_LSB(20), .TIMEOUT(TMO)) dut (
        .HCLK(HCLK), .HRESET(HRESET), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
        .HWRITE(HWRITE), .HSIZE(HSIZE), .HREADY(HREADY), .HWDATA(HWDATA),
        .HRDATA(HRDATA), .HREADYOUT(HREADYOUT), .HRESP(HRESP), .PADDR(PADDR),
        .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PWDATA(PWDATA),
        .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Expected outputs for the current cycle, written by the stimulus process.
    logic            e_hready, e_hresp, e_pen, e_pwrite, e_rst;
    logic [31:0]     e_hrdata, e_paddr, e_pwdata;
    logic [NSLV-1:0] e_psel;
    logic            chk_en = 1'b0;
    logic [31:0]     m_hrdata;

    // Per-window observation counters for the directed checks.
    int win_id = 0, seen_win = 0;
    int mon_cyc, mon_lo, mon_resp, mon_psel_cyc, mon_pen, mon_paddr_moves;
    logic [NSLV-1:0] mon_psel_or;
    logic [31:0]     mon_paddr_first, mon_pwdata;

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    always @(negedge HCLK) begin
        if (chk_en) begin
            cmp("HREADYOUT", 32'(HREADYOUT), 32'(e_hready));
            cmp("HRESP", 32'(HRESP), 32'(e_hresp));
            cmp("HRDATA", HRDATA, e_hrdata);
            cmp("PSEL", 32'(PSEL), 32'(e_psel));
            cmp("PENABLE", 32'(PENABLE), 32'(e_pen));
            if (e_psel != '0 || e_rst) begin
                cmp("PADDR", PADDR, e_paddr);
                cmp("PWRITE", 32'(PWRITE), 32'(e_pwrite));
            end
            if ((e_psel != '0 && e_pwrite) || e_rst) cmp("PWDATA", PWDATA, e_pwdata);
        end
        if (seen_win != win_id) begin
            seen_win = win_id;
            mon_cyc = 0; mon_lo = 0; mon_resp = 0; mon_psel_cyc = 0; mon_pen = 0;
            mon_paddr_moves = 0; mon_psel_or = '0; mon_paddr_first = '0; mon_pwdata = '0;
        end
        mon_cyc++;
        if (!HREADYOUT) mon_lo++;
        if (HRESP) mon_resp++;
        if (PENABLE) mon_pen++;
        if (PSEL != '0) begin
            if (mon_psel_cyc == 0) mon_paddr_first = PADDR;
            else if (PADDR != mon_paddr_first) mon_paddr_moves++;
            mon_psel_cyc++;
            mon_psel_or = mon_psel_or | PSEL;
            mon_pwdata = PWDATA;
        end
    end

    task automatic noise();
        PRDATA  = {$urandom, $urandom, $urandom, $urandom};
        PREADY  = 4'($urandom);
        PSLVERR = 4'($urandom);
    endtask

    task automatic step();
        @(posedge HCLK); #1;
        noise();
    endtask

    task automatic settle();
        @(negedge HCLK); #1;
    endtask

    task automatic drive_idle();
        int r;
        r = $urandom_range(0, 2);
        HADDR = $urandom; HWRITE = 1'($urandom); HSIZE = 3'($urandom); HREADY = 1'b1;
        HSEL = 1'b1; HTRANS = 2'($urandom);
        if (r == 0) HSEL = 1'b0;
        else if (r == 1) HTRANS = {1'b0, 1'($urandom)};
        else HREADY = 1'b0;
    endtask

    task automatic busy_inputs();
        HSEL = 1'($urandom); HTRANS = 2'($urandom); HREADY = 1'($urandom);
        HADDR = $urandom; HWRITE = 1'($urandom); HWDATA = $urandom; HSIZE = 3'($urandom);
    endtask

    task automatic exp_set(input logic hr, input logic rsp, input logic [NSLV-1:0] ps, input logic pen);
        e_hready = hr; e_hresp = rsp; e_psel = ps; e_pen = pen; e_rst = 1'b0; e_hrdata = m_hrdata;
    endtask

    task automatic exp_idle();
        exp_set(1'b1, 1'b0, '0, 1'b0);
    endtask

    task automatic exp_rst_state();
        m_hrdata = '0;
        exp_set(1'b1, 1'b0, '0, 1'b0);
        e_rst = 1'b1; e_paddr = '0; e_pwrite = 1'b0; e_pwdata = '0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin drive_idle(); step(); exp_idle(); end
    endtask

    task automatic mclr();
        win_id++;
    endtask

    // One AHB transfer, accepted in the current cycle; w = PREADY-low ACCESS cycles.
    task automatic do_txn(input logic [31:0] a, input logic wr, input logic [31:0] wd,
                          input int w, input logic err, input logic [31:0] rd, input int rst_at);
        logic            hit, ok;
        int              slot;
        logic [NSLV-1:0] onehot;
        hit    = (a[31:24] == 8'h40) && (int'(a[23:20]) < NSLV);
        slot   = int'(a[21:20]);
        onehot = NSLV'(1) << slot;
        HSEL = 1'b1; HTRANS = $urandom_range(0, 1) ? 2'b10 : 2'b11; HREADY = 1'b1;
        HADDR = a; HWRITE = wr; HSIZE = 3'($urandom);
        step(); busy_inputs();
        if (!hit) begin
            exp_set(1'b0, 1'b1, '0, 1'b0);
            step(); busy_inputs();
            exp_set(1'b1, 1'b1, '0, 1'b0);
            drive_idle();
            return;
        end
        if (wr) begin
            exp_set(1'b0, 1'b0, '0, 1'b0);
            HWDATA = wd;
            step(); busy_inputs();
            e_pwdata = wd;
        end
        e_paddr = {a[31:2], 2'b00}; e_pwrite = wr;
        exp_set(1'b0, 1'b0, onehot, 1'b0);
        step(); busy_inputs();
        ok = 1'b0;
        for (int j = 0; j <= TMO; j++) begin
            exp_set(1'b0, 1'b0, onehot, 1'b1);
            PREADY[slot]  = (j == w);
            PSLVERR[slot] = (j == w) ? err : 1'($urandom);
            PRDATA[32*slot +: 32] = rd;
            if (j == rst_at) begin
                HRESET = 1'b1;
                step();
                HRESET = 1'b0;
                exp_rst_state();
                drive_idle();
                return;
            end
            step(); busy_inputs();
            if (j == w) begin ok = !err; break; end
        end
        if (ok) begin
            if (!wr) m_hrdata = rd;
            exp_set(1'b1, 1'b0, '0, 1'b0);
        end else begin
            exp_set(1'b0, 1'b1, '0, 1'b0);
            step(); busy_inputs();
            exp_set(1'b1, 1'b1, '0, 1'b0);
        end
        drive_idle();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        int          r;
        HRESET = 1'b1; HWDATA = '0; m_hrdata = '0;
        drive_idle(); noise(); exp_rst_state();
        repeat (3) @(posedge HCLK);
        #1;
        HRESET = 1'b0;
        exp_rst_state();
        chk_en = 1'b1;
        settle();
        cmp("rst_hreadyout", 32'(HREADYOUT), 32'd1);
        cmp("rst_hresp", 32'(HRESP), 32'd0);
        cmp("rst_psel", 32'(PSEL), 32'd0);
        cmp("rst_paddr", PADDR, 32'd0);
        idle(2);

        // Write 5 to the timer
        settle(); mclr();
        do_txn(32'h4010_0004, 1'b1, 32'h5, 0, 1'b0, 32'h0, -1);
        settle();
        cmp("wr_wait_states", 32'(mon_lo), 32'd3);
        cmp("wr_psel_cycles", 32'(mon_psel_cyc), 32'd2);
        cmp("wr_psel_onehot", 32'(mon_psel_or), 32'h2);
        cmp("wr_penable_cycles", 32'(mon_pen), 32'd1);
        cmp("wr_pwdata", mon_pwdata, 32'h5);
        cmp("wr_hresp_cycles", 32'(mon_resp), 32'd0);
        idle(1);

        // Read from the timer
        settle(); mclr();
        do_txn(32'h4010_0008, 1'b0, 32'h0, 0, 1'b0, 32'h1234, -1);
        settle();
        cmp("rd_hrdata", HRDATA, 32'h1234);
        cmp("rd_wait_states", 32'(mon_lo), 32'd2);
        cmp("rd_cycles", 32'(mon_cyc), 32'd3);
        idle(1);

        // Decode misses: wrong base and slot beyond NSLV
        for (int k = 0; k < 2; k++) begin
            a = (k == 0) ? 32'h5000_0000 : 32'h4040_0000;
            settle(); mclr();
            do_txn(a, 1'b0, 32'h0, 0, 1'b0, 32'hDEAD_BEEF, -1);
            settle();
            cmp("miss_psel", 32'(mon_psel_or), 32'd0);
            cmp("miss_hresp_cycles", 32'(mon_resp), 32'd2);
            cmp("miss_wait_states", 32'(mon_lo), 32'd1);
            cmp("miss_hrdata_hold", HRDATA, 32'h1234);
            idle(1);
        end

        // Three APB wait states then PSLVERR
        settle(); mclr();
        do_txn(32'h4010_0010, 1'b0, 32'h0, 3, 1'b1, 32'h7777_7777, -1);
        settle();
        cmp("slverr_access_cycles", 32'(mon_pen), 32'd4);
        cmp("slverr_psel_cycles", 32'(mon_psel_cyc), 32'd5);
        cmp("slverr_paddr_stable", 32'(mon_paddr_moves), 32'd0);
        cmp("slverr_hresp_cycles", 32'(mon_resp), 32'd2);
        cmp("slverr_hrdata_hold", HRDATA, 32'h1234);
        idle(1);

        // Timeout, then a normal transfer straight out of ERR2
        settle(); mclr();
        do_txn(32'h4010_0000, 1'b0, 32'h0, 50, 1'b0, 32'h0, -1);
        settle();
        cmp("tmo_access_cycles", 32'(mon_pen), 32'd5);
        cmp("tmo_hresp_cycles", 32'(mon_resp), 32'd2);
        do_txn(32'h4010_0020, 1'b0, 32'h0, 1, 1'b0, 32'hCAFE_0001, -1);
        settle();
        cmp("after_tmo_hrdata", HRDATA, 32'hCAFE_0001);
        idle(1);

        // Read slot 1 then write slot 2, pipelined through DONE
        settle(); mclr();
        do_txn(32'h4010_0000, 1'b0, 32'h0, 0, 1'b0, 32'hA5A5_0000, -1);
        do_txn(32'h4020_0000, 1'b1, 32'h0000_00C3, 0, 1'b0, 32'h0, -1);
        settle();
        cmp("b2b_cycles", 32'(mon_cyc), 32'd7);
        cmp("b2b_wait_states", 32'(mon_lo), 32'd5);
        cmp("b2b_psel_onehot", 32'(mon_psel_or), 32'h6);

        // Random traffic
        for (int n = 0; n < 300; n++) begin
            idle($urandom_range(0, 2));
            r = $urandom_range(0, 9);
            if (r == 0)      a = {8'h41 + 8'($urandom_range(0, 100)), 24'($urandom)};
            else if (r == 1) a = {8'h40, 4'($urandom_range(4, 15)), 20'($urandom)};
            else             a = {8'h40, 4'($urandom_range(0, 3)), 20'($urandom)};
            do_txn(a, 1'($urandom), $urandom, $urandom_range(0, 6),
                   ($urandom_range(0, 3) == 0), $urandom, -1);
        end

        // Reset during ACCESS
        idle(1);
        do_txn(32'h4010_0000, 1'b0, 32'h0, 8, 1'b0, 32'h0, 1);
        settle();
        cmp("midrst_psel", 32'(PSEL), 32'd0);
        cmp("midrst_penable", 32'(PENABLE), 32'd0);
        cmp("midrst_hreadyout", 32'(HREADYOUT), 32'd1);
        cmp("midrst_hrdata", HRDATA, 32'd0);
        idle(2);
        do_txn(32'h4030_0040, 1'b0, 32'h0, 2, 1'b0, 32'h1357_9BDF, -1);
        settle();
        cmp("post_rst_hrdata", HRDATA, 32'h1357_9BDF);
        idle(2);

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
